// File: rtl/dmem_arbiter.sv
// Two-port (core C, loader L) arbiter in front of a single-port data RAM.
// Define DMEM_ARB_FIXED_PRIO_EN to give C fixed priority instead of round-robin.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RAM_AW = 10
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              ram_wread,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RDATA  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              win_q, win_d;   // 1 = loader owns the current access
   logic              we_q, we_d;
   logic [RAM_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] c_rdata_q, c_rdata_d, l_rdata_q, l_rdata_d;
   logic              c_rvalid_q, c_rvalid_d, l_rvalid_q, l_rvalid_d;
   logic              pick_l;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{c_addr[ADDR_W-1:RAM_AW+2], c_addr[1:0],
                               l_addr[ADDR_W-1:RAM_AW+2], l_addr[1:0]};

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign pick_l = !c_req;
`else
   logic last_q, last_d;   // 1 = loader was granted most recently

   assign pick_l = l_req && (!c_req || !last_q);

   always_comb begin
      last_d = last_q;
      if (state_q == S_ACCESS) last_d = win_q;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) last_q <= 1'b1;
      else          last_q <= last_d;
   end
`endif

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      c_rdata_d  = c_rdata_q;
      l_rdata_d  = l_rdata_q;
      c_rvalid_d = 1'b0;
      l_rvalid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (c_req || l_req) begin
               state_d = S_ACCESS;
               win_d   = pick_l;
               we_d    = pick_l ? l_we : c_we;
               addr_d  = pick_l ? l_addr[RAM_AW+1:2] : c_addr[RAM_AW+1:2];
               wdata_d = pick_l ? l_wdata : c_wdata;
            end
         end
         S_ACCESS: state_d = we_q ? S_IDLE : S_RDATA;
         S_RDATA: begin
            // RAM data is registered here so no requester sees it combinationally
            state_d = S_IDLE;
            if (win_q) begin
               l_rdata_d  = ram_rdata;
               l_rvalid_d = 1'b1;
            end else begin
               c_rdata_d  = ram_rdata;
               c_rvalid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         win_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         c_rdata_q  <= '0;
         l_rdata_q  <= '0;
         c_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         c_rdata_q  <= c_rdata_d;
         l_rdata_q  <= l_rdata_d;
         c_rvalid_q <= c_rvalid_d;
         l_rvalid_q <= l_rvalid_d;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_data  = wdata_q;
   assign ram_wren  = (state_q == S_ACCESS) &&  we_q;
   assign ram_wread = (state_q == S_ACCESS) && !we_q;
   assign c_gnt     = (state_q == S_ACCESS) && !win_q;
   assign l_gnt     = (state_q == S_ACCESS) &&  win_q;
   assign c_rvalid  = c_rvalid_q;
   assign l_rvalid  = l_rvalid_q;
   assign c_rdata   = c_rdata_q;
   assign l_rdata   = l_rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM model.
module tb_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        c_req, c_we, l_req, l_we;
   logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
   logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
   logic [31:0] c_rdata, l_rdata;
   logic [9:0]  ram_addr;
   logic [31:0] ram_data;
   logic        ram_wren, ram_wread;
   logic [31:0] ram_rdata;
   logic        busy;

   logic [31:0] mem [1024];
   int          checks = 0;
   int          passes = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_AW(10)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_wread(ram_wread), .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
      ram_rdata <= '0;
   end

   always @(posedge CLK) begin
      if (ram_wren)  mem[ram_addr] <= ram_data;
      if (ram_wread) ram_rdata     <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_c_gnt"},  32'(c_gnt),  32'd0);
      chk({tag, "_l_gnt"},  32'(l_gnt),  32'd0);
      chk({tag, "_c_rv"},   32'(c_rvalid), 32'd0);
      chk({tag, "_l_rv"},   32'(l_rvalid), 32'd0);
      chk({tag, "_busy"},   32'(busy),   32'd0);
   endtask

   initial begin
      RESET_N = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h1111_1111;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h24; l_wdata = 32'h2222_2222;

      // Reset with both requesting: every output held at zero
      tick(); tick();
      chk_idle_outputs("rst");
      chk("rst_c_rdata",  c_rdata,  32'd0);
      chk("rst_l_rdata",  l_rdata,  32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_data", ram_data, 32'd0);
      chk("rst_ram_wren", 32'(ram_wren),  32'd0);
      chk("rst_ram_wread", 32'(ram_wread), 32'd0);
      RESET_N = 1'b1;

      tick();
      chk("rr_first_c_gnt", 32'(c_gnt), 32'd1);
      chk("rr_first_l_gnt", 32'(l_gnt), 32'd0);
      chk("rr_first_wren",  32'(ram_wren), 32'd1);
      chk("rr_first_addr",  32'(ram_addr), 32'd8);
      chk("rr_first_data",  ram_data, 32'h1111_1111);
      c_req = 1'b0;
      tick();
      chk("rr_gap_busy", 32'(busy), 32'd0);
      chk("rr_gap_lgnt", 32'(l_gnt), 32'd0);
      tick();
      chk("rr_second_l_gnt", 32'(l_gnt), 32'd1);
      chk("rr_second_c_gnt", 32'(c_gnt), 32'd0);
      chk("rr_second_addr",  32'(ram_addr), 32'd9);
      l_req = 1'b0;
      tick();

      // Core write then read of byte address 0x10 (word 4)
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEAD_BEEF;
      tick();
      chk("cw_gnt",   32'(c_gnt), 32'd1);
      chk("cw_wren",  32'(ram_wren), 32'd1);
      chk("cw_wread", 32'(ram_wread), 32'd0);
      chk("cw_addr",  32'(ram_addr), 32'd4);
      chk("cw_data",  ram_data, 32'hDEAD_BEEF);
      c_req = 1'b0;
      tick();
      c_req = 1'b1; c_we = 1'b0;
      tick();
      chk("cr_gnt",   32'(c_gnt), 32'd1);
      chk("cr_wread", 32'(ram_wread), 32'd1);
      chk("cr_wren",  32'(ram_wren), 32'd0);
      c_req = 1'b0;
      tick();
      chk("cr_rdata_busy", 32'(busy), 32'd1);
      chk("cr_rdata_rv",   32'(c_rvalid), 32'd0);
      tick();
      chk("cr_rv",    32'(c_rvalid), 32'd1);
      chk("cr_rdata", c_rdata, 32'hDEAD_BEEF);
      tick();
      chk("cr_rv_once", 32'(c_rvalid), 32'd0);
      chk("cr_hold",    c_rdata, 32'hDEAD_BEEF);

      // Continuous reads from both ports; C was granted last
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h80;
      for (int k = 0; k < 4; k++) begin
         logic exp_l;
`ifdef DMEM_ARB_FIXED_PRIO_EN
         exp_l = 1'b0;
`else
         exp_l = (k % 2 == 0);
`endif
         tick();
         chk("rr_c_gnt", 32'(c_gnt), 32'(!exp_l));
         chk("rr_l_gnt", 32'(l_gnt), 32'(exp_l));
         tick();
         chk("rr_nogrant", 32'(c_gnt | l_gnt), 32'd0);
         tick();
         if (exp_l) begin
            chk("rr_l_rv",    32'(l_rvalid), 32'd1);
            chk("rr_l_rdata", l_rdata, 32'hA500_0020);
         end else begin
            chk("rr_c_rv",    32'(c_rvalid), 32'd1);
            chk("rr_c_rdata", c_rdata, 32'hA500_0010);
         end
      end
      c_req = 1'b0; l_req = 1'b0;
      tick();

      // Loader write at the top RAM word, core reads it through an aliased address
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0000_0FFC; l_wdata = 32'h1234_5678;
      tick();
      chk("lw_gnt",  32'(l_gnt), 32'd1);
      chk("lw_addr", 32'(ram_addr), 32'h3FF);
      chk("lw_wren", 32'(ram_wren), 32'd1);
      l_req = 1'b0;
      tick();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_1FFC;
      tick();
      chk("alias_addr", 32'(ram_addr), 32'h3FF);
      c_req = 1'b0;
      tick(); tick();
      chk("alias_rv",    32'(c_rvalid), 32'd1);
      chk("alias_rdata", c_rdata, 32'h1234_5678);
      tick();

      // Reset during the RDATA state of a loader read
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h80;
      tick();
      chk("abort_l_gnt", 32'(l_gnt), 32'd1);
      l_req = 1'b0;
      tick();
      chk("abort_busy_pre", 32'(busy), 32'd1);
      RESET_N = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      tick();
      chk("abort_l_rv", 32'(l_rvalid), 32'd0);
      RESET_N = 1'b1;
      tick();
      chk("abort_l_rv2", 32'(l_rvalid), 32'd0);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      tick();
      chk("post_c_gnt", 32'(c_gnt), 32'd1);
      c_req = 1'b0;
      tick(); tick();
      chk("post_c_rv",    32'(c_rvalid), 32'd1);
      chk("post_c_rdata", c_rdata, 32'hDEAD_BEEF);
      chk("post_l_rv",    32'(l_rvalid), 32'd0);
      tick();

      // Request withdrawn right after being sampled still completes once
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0FFC;
      tick();
      c_req = 1'b0;
      chk("drop_gnt", 32'(c_gnt), 32'd1);
      tick(); tick();
      chk("drop_rv",    32'(c_rvalid), 32'd1);
      chk("drop_rdata", c_rdata, 32'h1234_5678);
      tick();
      chk_idle_outputs("drop_end");
      tick();
      chk("drop_rv_once", 32'(c_rvalid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the core data port (port C) and a program/debug loader (port L).
- Sits between the core's daddr/ddata_w/MemRead/MemWrite/ddata_r pins and the RAM's address/data/wren/wread/salida pins.
- Serialises accesses through a 3-state FSM with round-robin arbitration.
- Returns read data with a valid pulse; asserts a busy flag so the core can stall.

Parameters:
- ADDR_W, 32, requester address width (byte address)
- DATA_W, 32, data word width
- RAM_AW, 10, RAM word-address width; RAM address = addr[RAM_AW+1:2]

Ports:
- CLK in 1: single clock, all state updates on rising edge
- RESET_N in 1: asynchronous, active-low reset
- c_req in 1: core access request, held until c_gnt
- c_we in 1: core write (1) / read (0)
- c_addr in ADDR_W: core byte address
- c_wdata in DATA_W: core write data
- c_gnt out 1: one-cycle pulse, core command issued to RAM
- c_rvalid out 1: one-cycle pulse, c_rdata valid
- c_rdata out DATA_W: core read data
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: same set for the loader
- ram_addr out RAM_AW: RAM word address
- ram_data out DATA_W: RAM write data
- ram_wren out 1: RAM write strobe
- ram_wread out 1: RAM read strobe
- ram_rdata in DATA_W: RAM read data, valid the cycle after ram_wread
- busy out 1: high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, last=L (so C wins first tie). All outputs 0, including every gnt/rvalid/rdata and every ram_* output.
- Reset asserted mid-operation aborts the access. A write not yet strobed is never performed; a pending rvalid is never produced.
- FSM states: IDLE, ACCESS, RDATA.
- IDLE transitions:
  - No request: stay.
  - Any request: select winner, register winner id, addr, we and wdata; go to ACCESS.
- ACCESS:
  - Drive ram_addr/ram_data from the registers.
  - Assert ram_wren=we or ram_wread=!we, exactly one cycle.
  - Pulse the winner's gnt; update last=winner.
  - Write: go to IDLE. Read: go to RDATA.
- RDATA:
  - Register ram_rdata into the winner's rdata at the edge.
  - Pulse the winner's rvalid in the following IDLE cycle.
  - rdata holds its value until the next read for that port.
- Latency, with request sampled at edge N:
  - gnt high in cycle N+1.
  - Read rvalid in cycle N+3.
  - Back-to-back throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: winner = !last (round-robin).
  - Ports are never granted in the same cycle.
- Requests are sampled only in IDLE. Requests arriving during ACCESS/RDATA wait.
- A request dropped after being latched still completes (the command is already committed). The requester must hold address, data and we until gnt.
- addr[1:0] and addr bits above RAM_AW+1 are ignored. No alignment fault.
- ram_data drives registered wdata even on reads. Read data from the RAM is never combinationally passed to a requester.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port C always wins a tie, and the last register is unused. Port L is served only when c_req=0 in IDLE, so starvation is permitted.
- Undefined: round-robin as above.

Test Plan:
- Reset with both req=1 -> all outputs 0 during reset. After release: c_gnt in cycle 1 (C first), then l_gnt 2 cycles later (writes).
- C write addr 0x0000_0010, data 0xDEADBEEF; then C read same addr -> ram_wren with ram_addr=4. Later c_rvalid=1 with c_rdata=0xDEADBEEF, 3 cycles after the read request.
- C and L read continuously -> grants alternate C, L, C, L every 3 cycles; no cycle with both gnt high. With DMEM_ARB_FIXED_PRIO_EN defined, only c_gnt pulses.
- L writes 0x12345678 to addr 0x0000_0FFC while C idles -> ram_addr=0x3FF. A following C read of 0x0000_1FFC returns 0x12345678 (upper bits ignored).
- RESET_N dropped during RDATA of an L read -> no l_rvalid pulse, busy=0 immediately. The next C request is served normally.
- C read request dropped after IDLE sample -> access still completes, c_rvalid pulses once.
